// File: rtl/eth_egress_pkt_arb.sv
// Packet-granular weighted round-robin arbiter for the Ethernet egress stream.
// Port 0 (CHDR) may take up to CHDR_BURST packets while port 1 (CPU) waits.
module eth_egress_pkt_arb #(
   parameter int unsigned ENET_W     = 64,
   parameter int unsigned USER_W     = 4,
   parameter int unsigned CHDR_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ENET_W-1:0] s0_tdata,
   input  logic [USER_W-1:0] s0_tuser,
   input  logic              s0_tlast,
   input  logic              s0_tvalid,
   output logic              s0_tready,
   input  logic [ENET_W-1:0] s1_tdata,
   input  logic [USER_W-1:0] s1_tuser,
   input  logic              s1_tlast,
   input  logic              s1_tvalid,
   output logic              s1_tready,
   output logic [ENET_W-1:0] m_tdata,
   output logic [USER_W-1:0] m_tuser,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [1:0]        active_port
);

   localparam logic [7:0] BurstMax = 8'(CHDR_BURST);

   typedef enum logic [1:0] {StIdle, StPass0, StPass1} state_e;

   state_e     state_q, state_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   // CPU was already waiting when the current CHDR packet was granted
   logic       s1_wait_q, s1_wait_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         burst_cnt_q <= 8'd0;
         s1_wait_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         s1_wait_q   <= s1_wait_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      s1_wait_d   = s1_wait_q;
      m_tdata     = '0;
      m_tuser     = '0;
      m_tlast     = 1'b0;
      m_tvalid    = 1'b0;
      s0_tready   = 1'b0;
      s1_tready   = 1'b0;
      active_port = 2'b00;

      case (state_q)
         StIdle: begin
            if (s0_tvalid && !(s1_tvalid && (burst_cnt_q == BurstMax))) begin
               state_d   = StPass0;
               s1_wait_d = s1_tvalid;
               if (!s1_tvalid) begin
                  burst_cnt_d = 8'd0;
               end
            end else if (s1_tvalid) begin
               state_d = StPass1;
            end
         end

         StPass0: begin
            m_tdata     = s0_tdata;
            m_tuser     = s0_tuser;
            m_tlast     = s0_tlast;
            m_tvalid    = s0_tvalid;
            s0_tready   = m_tready;
            active_port = 2'b10;
            if (s0_tvalid && m_tready && s0_tlast) begin
               state_d = StIdle;
               if (s1_wait_q && (burst_cnt_q < BurstMax)) begin
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end
         end

         StPass1: begin
            m_tdata     = s1_tdata;
            m_tuser     = s1_tuser;
            m_tlast     = s1_tlast;
            m_tvalid    = s1_tvalid;
            s1_tready   = m_tready;
            active_port = 2'b11;
            if (s1_tvalid && m_tready && s1_tlast) begin
               state_d     = StIdle;
               burst_cnt_d = 8'd0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_eth_egress_pkt_arb.sv
// Directed bench for eth_egress_pkt_arb at 512-bit width with CHDR_BURST=4.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_eth_egress_pkt_arb;

   localparam int EW = 512;
   localparam int UW = 7;

   logic          clk;
   logic          rst_n;
   logic [EW-1:0] s0_tdata, s1_tdata, m_tdata;
   logic [UW-1:0] s0_tuser, s1_tuser, m_tuser;
   logic          s0_tlast, s0_tvalid, s0_tready;
   logic          s1_tlast, s1_tvalid, s1_tready;
   logic          m_tlast, m_tvalid, m_tready;
   logic [1:0]    active_port;

   int n_checks = 0;
   int n_errors = 0;

   eth_egress_pkt_arb #(
      .ENET_W     (EW),
      .USER_W     (UW),
      .CHDR_BURST (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s0_tdata    (s0_tdata),
      .s0_tuser    (s0_tuser),
      .s0_tlast    (s0_tlast),
      .s0_tvalid   (s0_tvalid),
      .s0_tready   (s0_tready),
      .s1_tdata    (s1_tdata),
      .s1_tuser    (s1_tuser),
      .s1_tlast    (s1_tlast),
      .s1_tvalid   (s1_tvalid),
      .s1_tready   (s1_tready),
      .m_tdata     (m_tdata),
      .m_tuser     (m_tuser),
      .m_tlast     (m_tlast),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .active_port (active_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      s0_tdata  = '0;
      s0_tuser  = '0;
      s0_tlast  = 1'b0;
      s0_tvalid = 1'b0;
      s1_tdata  = '0;
      s1_tuser  = '0;
      s1_tlast  = 1'b0;
      s1_tvalid = 1'b0;
      m_tready  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Both ports saturated with single-beat packets; burst counter assumed at 0.
   task automatic run_both(input string tag, input int n_pkts, input logic [63:0] b0,
                           input logic [63:0] b1);
      int         k0 = 0;
      int         k1 = 0;
      int         n  = 0;
      logic       exp_port;
      logic [63:0] exp_data;
      for (int cyc = 0; cyc < 20 * n_pkts && n < n_pkts; cyc++) begin
         @(negedge clk);
         s0_tvalid = 1'b1;
         s0_tdata  = EW'(b0 + 64'(k0));
         s0_tlast  = 1'b1;
         s1_tvalid = 1'b1;
         s1_tdata  = EW'(b1 + 64'(k1));
         s1_tlast  = 1'b1;
         m_tready  = 1'b1;
         #1;
         if (m_tvalid) begin
            exp_port = (n % 5 == 4);
            exp_data = exp_port ? b1 + 64'(k1) : b0 + 64'(k0);
            check_eq({tag, "_port"}, 64'(active_port), 64'({1'b1, exp_port}));
            check_eq({tag, "_data"}, m_tdata[63:0], exp_data);
            n++;
         end
         if (s0_tready) k0++;
         if (s1_tready) k1++;
      end
      check_eq({tag, "_count"}, 64'(n), 64'(n_pkts));
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      int   beat, idx, s0i, s1i, outn, g;
      int   t_cyc [12];
      logic got;
      logic [63:0] exp_data;

      rst_n = 1'b0;
      clear_inputs();
      s0_tvalid = 1'b1;
      s1_tvalid = 1'b1;
      m_tready  = 1'b1;
      @(negedge clk);
      #1;
      check_eq("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("rst_s0_tready", 64'(s0_tready), 64'd0);
      check_eq("rst_s1_tready", 64'(s1_tready), 64'd0);
      check_eq("rst_active", 64'(active_port), 64'd0);
      do_reset();

      // 1: only port 0, three 4-beat packets
      beat = 0;
      foreach (t_cyc[i]) t_cyc[i] = 0;
      for (int cyc = 0; cyc < 100 && beat < 12; cyc++) begin
         @(negedge clk);
         s0_tvalid = 1'b1;
         s0_tdata  = EW'(64'h100 + 64'(beat));
         s0_tlast  = (beat % 4 == 3);
         m_tready  = 1'b1;
         #1;
         check_eq("t1_s1_tready", 64'(s1_tready), 64'd0);
         if (m_tvalid && m_tready) begin
            check_eq("t1_data", m_tdata[63:0], 64'h100 + 64'(beat));
            check_eq("t1_port", 64'(active_port), 64'b10);
            check_eq("t1_tlast", 64'(m_tlast), 64'(beat % 4 == 3));
            t_cyc[beat] = cyc;
            beat++;
         end
      end
      check_eq("t1_count", 64'(beat), 64'd12);
      for (int p = 0; p < 3; p++) begin
         for (int b = 1; b < 4; b++)
            check_eq("t1_b2b", 64'(t_cyc[p*4+b] - t_cyc[p*4+b-1]), 64'd1);
         if (p > 0) check_eq("t1_gap", 64'(t_cyc[p*4] - t_cyc[p*4-1]), 64'd2);
      end
      @(negedge clk);
      clear_inputs();

      // 2: both saturated, 4 CHDR then 1 CPU
      do_reset();
      run_both("t2", 20, 64'h200, 64'h300);

      // 3: 8-beat CPU packet under toggling backpressure while CHDR waits
      do_reset();
      idx = 0;
      for (int cyc = 0; cyc < 100 && idx < 8; cyc++) begin
         @(negedge clk);
         s1_tvalid = 1'b1;
         s1_tdata  = EW'(64'h400 + 64'(idx));
         s1_tlast  = (idx == 7);
         s0_tvalid = (cyc > 0);
         s0_tdata  = EW'(64'h4AA);
         s0_tlast  = 1'b1;
         m_tready  = (cyc % 2 == 1);
         #1;
         check_eq("t3_s0_tready", 64'(s0_tready), 64'd0);
         if (m_tvalid) begin
            check_eq("t3_data", m_tdata[63:0], 64'h400 + 64'(idx));
            check_eq("t3_port", 64'(active_port), 64'b11);
            if (m_tready) idx++;
         end
      end
      check_eq("t3_count", 64'(idx), 64'd8);
      got = 1'b0;
      for (int cyc = 0; cyc < 10 && !got; cyc++) begin
         @(negedge clk);
         s1_tvalid = 1'b0;
         m_tready  = 1'b1;
         #1;
         if (m_tvalid) begin
            check_eq("t3_s0_data", m_tdata[63:0], 64'h4AA);
            check_eq("t3_s0_port", 64'(active_port), 64'b10);
            got = 1'b1;
         end
      end
      check_eq("t3_s0_seen", 64'(got), 64'd1);
      @(negedge clk);
      clear_inputs();

      // 4: port 0 valid gaps mid-packet must not release the grant
      do_reset();
      s0i  = 0;
      s1i  = 0;
      outn = 0;
      for (int cyc = 0; cyc < 100 && outn < 6; cyc++) begin
         @(negedge clk);
         m_tready  = 1'b1;
         s0_tvalid = (s0i < 4) && !(s0i > 0 && cyc % 2 == 0);
         s0_tdata  = EW'(64'h500 + 64'(s0i));
         s0_tlast  = (s0i == 3);
         s1_tvalid = (s1i < 2);
         s1_tdata  = EW'(64'h600 + 64'(s1i));
         s1_tlast  = (s1i == 1);
         #1;
         if (s0i > 0 && s0i < 4) check_eq("t4_hold", 64'(active_port), 64'b10);
         if (outn < 4) check_eq("t4_s1_tready", 64'(s1_tready), 64'd0);
         if (m_tvalid) begin
            exp_data = (outn < 4) ? 64'h500 + 64'(outn) : 64'h600 + 64'(outn - 4);
            check_eq("t4_data", m_tdata[63:0], exp_data);
            check_eq("t4_port", 64'(active_port), (outn < 4) ? 64'b10 : 64'b11);
            outn++;
         end
         if (s0_tvalid && s0_tready) s0i++;
         if (s1_tvalid && s1_tready) s1i++;
      end
      check_eq("t4_count", 64'(outn), 64'd6);
      @(negedge clk);
      clear_inputs();

      // 5: reset on beat 3 of a 6-beat packet after burst count reached 3
      do_reset();
      g = 0;
      got = 1'b0;
      for (int cyc = 0; cyc < 100 && !got; cyc++) begin
         @(negedge clk);
         m_tready  = 1'b1;
         s0_tvalid = 1'b1;
         s0_tdata  = EW'(64'h700 + 64'(g));
         s0_tlast  = (g < 3) || (g == 8);
         s1_tvalid = 1'b1;
         s1_tdata  = EW'(64'h7FF);
         s1_tlast  = 1'b1;
         #1;
         if (g == 5 && m_tvalid) begin
            got = 1'b1;
         end else begin
            if (m_tvalid) check_eq("t5_pre_port", 64'(active_port), 64'b10);
            if (s0_tready) g++;
         end
      end
      check_eq("t5_reached", 64'(got), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_m_tvalid", 64'(m_tvalid), 64'd0);
      check_eq("t5_s0_tready", 64'(s0_tready), 64'd0);
      check_eq("t5_s1_tready", 64'(s1_tready), 64'd0);
      check_eq("t5_active", 64'(active_port), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_both("t5", 5, 64'h800, 64'h900);

      // 6: wide data and byte count pass through on the last beat
      do_reset();
      idx = 0;
      for (int cyc = 0; cyc < 20 && idx < 2; cyc++) begin
         @(negedge clk);
         m_tready  = 1'b1;
         s1_tvalid = 1'b1;
         s1_tdata  = {8{64'hC0DE_0000_0000_0000 | 64'(idx)}};
         s1_tuser  = (idx == 1) ? 7'd37 : 7'd0;
         s1_tlast  = (idx == 1);
         #1;
         if (m_tvalid) begin
            check_eq("t6_data_hi", m_tdata[511:448], 64'hC0DE_0000_0000_0000 | 64'(idx));
            check_eq("t6_tlast", 64'(m_tlast), 64'(idx == 1));
            if (idx == 1) check_eq("t6_tuser", 64'(m_tuser), 64'd37);
            idx++;
         end
      end
      check_eq("t6_count", 64'(idx), 64'd2);
      @(negedge clk);
      clear_inputs();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
